// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the MEM-stage access unit.
//   - state_t         : access FSM encoding (IDLE / WAIT)
//   - ALIGN_BITS      : low address bits that must be zero for a word access
//   - word_align()    : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam int ALIGN_BITS = 2;

   // Word-align mask applied to the outgoing address; the request only issues
   // for aligned addresses, so this is a safety net for the memory side.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
//   Counts WAIT cycles spent without a memory acknowledge.
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset
//     i_clear        load zero (takes priority over enable)
//     i_enable       increment by one
//     o_expired      count has reached TIMEOUT_CYCLES-1 (last WAIT cycle)
// -----------------------------------------------------------------------------
module mem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)         r_cnt <= '0;
      else if (i_clear)  r_cnt <= '0;
      else if (i_enable) r_cnt <= r_cnt + 1'b1;
   end

   assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM stage: performs lw/sw against a multi-cycle data memory over a
//   req/ack handshake, stalls the front of the pipe while an access is
//   outstanding, resolves branches and drives the MEM/WB register.
//   Ports:
//     i_clk, i_rst                       clock, synchronous active-high reset
//     i_branch, i_zero, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg,
//     i_branch_target, i_addr, i_write_data, i_dest_reg   EX/MEM inputs
//     o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata            memory request
//     i_mem_rdata, i_mem_ack                               memory response
//     o_stall          comb., freezes PC..EX/MEM
//     o_pc_src, o_branch_target_out                        comb. branch resolve
//     o_reg_write, o_mem_to_reg, o_read_data, o_alu_result, o_dest_reg  MEM/WB
//     o_align_err, o_bus_err                               one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_branch,
   input  logic              i_zero,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_reg_write,
   input  logic              i_mem_to_reg,
   input  logic [DATA_W-1:0] i_branch_target,
   input  logic [DATA_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_write_data,
   input  logic [4:0]        i_dest_reg,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ack,
   output logic              o_stall,
   output logic              o_pc_src,
   output logic [DATA_W-1:0] o_branch_target_out,
   output logic              o_reg_write,
   output logic              o_mem_to_reg,
   output logic [DATA_W-1:0] o_read_data,
   output logic [DATA_W-1:0] o_alu_result,
   output logic [4:0]        o_dest_reg,
   output logic              o_align_err,
   output logic              o_bus_err
);

   state_t r_state, w_state_nxt;

   logic w_access, w_misaligned, w_issue;
   logic w_cnt_clr, w_cnt_en, w_expired;

   // Copies of the EX/MEM controls taken when the request issues, so the
   // write-back still sees them even if the stall logic upstream misbehaves.
   logic              r_lat_reg_write, r_lat_mem_to_reg;
   logic [4:0]        r_lat_dest;
   logic [DATA_W-1:0] r_lat_addr;

   assign w_access     = i_mem_read | i_mem_write;
   assign w_misaligned = |i_addr[ALIGN_BITS-1:0];
   assign w_issue      = w_access & ~w_misaligned;

   assign o_pc_src            = i_branch & i_zero;
   assign o_branch_target_out = i_branch_target;

   mem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_cnt_clr),
      .i_enable  (w_cnt_en),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      o_stall     = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               o_stall     = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Ack beats a coincident timeout.
            if (i_mem_ack || w_expired) begin
               w_state_nxt = ST_IDLE;
            end else begin
               o_stall  = 1'b1;
               w_cnt_en = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mem_req        <= 1'b0;
         o_mem_we         <= 1'b0;
         o_mem_addr       <= '0;
         o_mem_wdata      <= '0;
         o_reg_write      <= 1'b0;
         o_mem_to_reg     <= 1'b0;
         o_read_data      <= '0;
         o_alu_result     <= '0;
         o_dest_reg       <= '0;
         o_align_err      <= 1'b0;
         o_bus_err        <= 1'b0;
         r_lat_reg_write  <= 1'b0;
         r_lat_mem_to_reg <= 1'b0;
         r_lat_dest       <= '0;
         r_lat_addr       <= '0;
      end else begin
         o_align_err <= 1'b0;
         o_bus_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_access) begin
                  o_reg_write  <= i_reg_write;
                  o_mem_to_reg <= i_mem_to_reg;
                  o_alu_result <= i_addr;
                  o_dest_reg   <= i_dest_reg;
               end else if (w_misaligned) begin
                  o_align_err  <= 1'b1;
                  o_reg_write  <= 1'b0;
                  o_mem_to_reg <= 1'b0;
               end else begin
                  o_mem_req        <= 1'b1;
                  o_mem_we         <= i_mem_write;  // write wins over read
                  o_mem_addr       <= DATA_W'(word_align(32'(i_addr)));
                  o_mem_wdata      <= i_write_data;
                  r_lat_reg_write  <= i_reg_write;
                  r_lat_mem_to_reg <= i_mem_to_reg;
                  r_lat_dest       <= i_dest_reg;
                  r_lat_addr       <= i_addr;
                  o_reg_write      <= 1'b0;        // bubble into MEM/WB
               end
            end
            ST_WAIT: begin
               if (i_mem_ack) begin
                  o_mem_req    <= 1'b0;
                  o_mem_we     <= 1'b0;
                  if (!o_mem_we) o_read_data <= i_mem_rdata;
                  o_reg_write  <= r_lat_reg_write;
                  o_mem_to_reg <= r_lat_mem_to_reg;
                  o_dest_reg   <= r_lat_dest;
                  o_alu_result <= r_lat_addr;
               end else if (w_expired) begin
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_bus_err   <= 1'b1;
                  o_reg_write <= 1'b0;
               end else begin
                  o_reg_write <= 1'b0;
               end
            end
            default: o_mem_req <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed vectors with hand-computed expectations for mem_access_unit.
//   Inputs change 1ns after the rising edge; outputs are sampled after that.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        branch, zero, mem_read, mem_write, reg_write_in, mem_to_reg_in;
   logic [31:0] branch_target, addr, write_data, mem_rdata;
   logic [4:0]  dest_reg;
   logic        mem_ack;
   logic        mem_req, mem_we, stall, pc_src;
   logic [31:0] mem_addr, mem_wdata, branch_target_out, read_data, alu_result;
   logic        reg_write, mem_to_reg, align_err, bus_err;
   logic [4:0]  dest_out;

   int n_tests = 0;
   int n_fail  = 0;
   int n_stall;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_W(32), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_branch            (branch),
      .i_zero              (zero),
      .i_mem_read          (mem_read),
      .i_mem_write         (mem_write),
      .i_reg_write         (reg_write_in),
      .i_mem_to_reg        (mem_to_reg_in),
      .i_branch_target     (branch_target),
      .i_addr              (addr),
      .i_write_data        (write_data),
      .i_dest_reg          (dest_reg),
      .o_mem_req           (mem_req),
      .o_mem_we            (mem_we),
      .o_mem_addr          (mem_addr),
      .o_mem_wdata         (mem_wdata),
      .i_mem_rdata         (mem_rdata),
      .i_mem_ack           (mem_ack),
      .o_stall             (stall),
      .o_pc_src            (pc_src),
      .o_branch_target_out (branch_target_out),
      .o_reg_write         (reg_write),
      .o_mem_to_reg        (mem_to_reg),
      .o_read_data         (read_data),
      .o_alu_result        (alu_result),
      .o_dest_reg          (dest_out),
      .o_align_err         (align_err),
      .o_bus_err           (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      branch = 0; zero = 0; mem_read = 0; mem_write = 0;
      reg_write_in = 0; mem_to_reg_in = 0; mem_ack = 0;
      addr = 0; write_data = 0; dest_reg = 0; branch_target = 0;
   endtask

   task automatic set_lw(input logic [31:0] a, input logic [4:0] rd);
      nop();
      mem_read = 1; reg_write_in = 1; mem_to_reg_in = 1; addr = a; dest_reg = rd;
   endtask

   initial begin
      nop();
      mem_rdata = 0;
      rst = 1;
      step(); step();
      rst = 0;
      #1;
      chk("rst_req",   32'(mem_req),   0);
      chk("rst_rw",    32'(reg_write), 0);
      chk("rst_alu",   alu_result,     0);
      chk("rst_rdata", read_data,      0);
      chk("rst_err",   32'({align_err, bus_err}), 0);
      chk("rst_stall", 32'(stall),     0);

      // R-type pass-through
      addr = 32'h1234; reg_write_in = 1; dest_reg = 5;
      #1 chk("rt_stall", 32'(stall), 0);
      step();
      chk("rt_alu",   alu_result,     32'h1234);
      chk("rt_rw",    32'(reg_write), 1);
      chk("rt_dest",  32'(dest_out),  5);
      chk("rt_stall2",32'(stall),     0);

      // lw 0x40, ack after 3 WAIT cycles
      set_lw(32'h40, 7);
      mem_rdata = 32'hDEADBEEF;
      n_stall = 0;
      #1 n_stall += int'(stall);
      step();
      chk("lw_req",  32'(mem_req),   1);
      chk("lw_addr", mem_addr,       32'h40);
      chk("lw_we",   32'(mem_we),    0);
      chk("lw_bub",  32'(reg_write), 0);
      for (int i = 0; i < 3; i++) begin
         n_stall += int'(stall);
         step();
         chk("lw_hold", 32'(mem_req), 1);
      end
      mem_ack = 1;
      #1 n_stall += int'(stall);
      chk("lw_ack_stall", 32'(stall), 0);
      step();
      nop();
      chk("lw_nstall", 32'(n_stall),  4);
      chk("lw_req0",   32'(mem_req),  0);
      chk("lw_data",   read_data,     32'hDEADBEEF);
      chk("lw_mtr",    32'(mem_to_reg), 1);
      chk("lw_rw",     32'(reg_write),  1);
      chk("lw_dest",   32'(dest_out),   7);

      // sw 0x44, immediate ack
      mem_write = 1; addr = 32'h44; write_data = 32'hCAFEF00D;
      #1 chk("sw_stall", 32'(stall), 1);
      step();
      chk("sw_req",   32'(mem_req), 1);
      chk("sw_we",    32'(mem_we),  1);
      chk("sw_addr",  mem_addr,     32'h44);
      chk("sw_wdata", mem_wdata,    32'hCAFEF00D);
      mem_ack = 1;
      #1 chk("sw_ack_stall", 32'(stall), 0);
      step();
      nop();
      chk("sw_req0",  32'(mem_req),   0);
      chk("sw_rw",    32'(reg_write), 0);
      chk("sw_keep",  read_data,      32'hDEADBEEF);

      // misaligned lw 0x42
      set_lw(32'h42, 3);
      #1 chk("al_stall", 32'(stall), 0);
      step();
      nop();
      chk("al_req",  32'(mem_req),   0);
      chk("al_err",  32'(align_err), 1);
      chk("al_rw",   32'(reg_write), 0);
      step();
      chk("al_pulse", 32'(align_err), 0);

      // lw with no ack -> bus error after 16 WAIT cycles
      set_lw(32'h80, 9);
      step();
      for (int i = 0; i < 15; i++) begin
         chk("to_stall", 32'(stall), 1);
         step();
      end
      chk("to_last_stall", 32'(stall), 0);
      chk("to_req_last",   32'(mem_req), 1);
      step();
      nop();
      chk("to_buserr", 32'(bus_err),   1);
      chk("to_req0",   32'(mem_req),   0);
      chk("to_rw",     32'(reg_write), 0);
      step();
      chk("to_pulse",  32'(bus_err),   0);

      // ack on the final WAIT cycle wins over timeout
      set_lw(32'h84, 10);
      mem_rdata = 32'h600DF00D;
      step();
      for (int i = 0; i < 15; i++) step();
      mem_ack = 1;
      step();
      nop();
      chk("ta_buserr", 32'(bus_err),   0);
      chk("ta_req0",   32'(mem_req),   0);
      chk("ta_data",   read_data,      32'h600DF00D);
      chk("ta_rw",     32'(reg_write), 1);

      // ack while idle is ignored
      mem_ack = 1; mem_rdata = 32'h55555555;
      step();
      mem_ack = 0;
      chk("idle_ack_data", read_data,    32'h600DF00D);
      chk("idle_ack_req",  32'(mem_req), 0);

      // branch resolves during a stall, then reset mid-WAIT
      set_lw(32'h90, 4);
      step();
      branch = 1; zero = 1; branch_target = 32'h1000;
      #1;
      chk("br_stall",  32'(stall),        1);
      chk("br_pcsrc",  32'(pc_src),       1);
      chk("br_target", branch_target_out, 32'h1000);
      zero = 0;
      #1 chk("br_nz", 32'(pc_src), 0);
      rst = 1;
      step();
      rst = 0;
      nop();
      #1;
      chk("mrst_req",   32'(mem_req),   0);
      chk("mrst_rdata", read_data,      0);
      chk("mrst_dest",  32'(dest_out),  0);
      chk("mrst_stall", 32'(stall),     0);
      step();
      chk("mrst_idle",  32'(mem_req),   0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
